// File: rtl/lcd_frame_streamer_pkg.sv
// Shared definitions for the PCD8544 frame streamer: FSM state encoding,
// controller opcodes and default geometry/timing parameters.
package lcd_frame_streamer_pkg;

    typedef enum logic [2:0] {
        ST_LRST  = 3'd0,  // holding the LCD reset pin low
        ST_INIT  = 3'd1,  // sending the init command list
        ST_IDLE  = 3'd2,  // waiting for frame_start
        ST_HOME0 = 3'd3,  // sending SET_Y
        ST_HOME1 = 3'd4,  // sending SET_X
        ST_FETCH = 3'd5,  // frame-buffer address presented, RAM read in flight
        ST_DATA  = 3'd6   // frame-buffer byte offered to the transmitter
    } state_t;

    // PCD8544 opcodes used by the init list and the home-cursor sequence.
    localparam logic [7:0] FUNC_EXT    = 8'h21;  // PD=0, V=0, H=1 (extended set)
    localparam logic [7:0] VOP         = 8'hB1;  // contrast
    localparam logic [7:0] TEMP        = 8'h04;  // temperature coefficient 0
    localparam logic [7:0] BIAS        = 8'h14;  // bias 1:48
    localparam logic [7:0] FUNC_BASIC  = 8'h20;  // back to the basic set
    localparam logic [7:0] DISP_NORMAL = 8'h0C;  // normal display mode
    localparam logic [7:0] SET_Y       = 8'h40;  // Y (bank) address 0
    localparam logic [7:0] SET_X       = 8'h80;  // X (column) address 0

    localparam int FB_BYTES_DEFAULT   = 504;  // 84 x 48 pixels / 8
    localparam int RST_CYCLES_DEFAULT = 100;
    localparam int INIT_LEN_DEFAULT   = 6;

endpackage

// File: rtl/lcd_frame_streamer_if.sv
// Byte hand-off to the SPI transmitter plus the frame-buffer read port.
interface lcd_frame_streamer_if;

    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_dc;
    logic [8:0] fb_addr;
    logic [7:0] fb_data;

    // Streamer side: offers bytes and reads the frame buffer.
    modport master (
        output tx_valid, tx_data, tx_dc, fb_addr,
        input  tx_ready, fb_data
    );

    // Transmitter / RAM side.
    modport slave (
        input  tx_valid, tx_data, tx_dc, fb_addr,
        output tx_ready, fb_data
    );

endinterface

// File: rtl/lcd_frame_streamer_init_rom.sv
// Fixed PCD8544 power-up command list, indexed combinationally.
module lcd_frame_streamer_init_rom
    import lcd_frame_streamer_pkg::*;
(
    input  logic [2:0] index,
    output logic [7:0] value
);

    // Index-to-opcode lookup; slots past the list read as 8'h00 (NOP).
    always_comb begin
        // NOTE: assign a default first so every path drives value and no latch is inferred.
        value = 8'h00;
        case (index)
            3'd0:    value = FUNC_EXT;
            3'd1:    value = VOP;
            3'd2:    value = TEMP;
            3'd3:    value = BIAS;
            3'd4:    value = FUNC_BASIC;
            3'd5:    value = DISP_NORMAL;
            default: value = 8'h00;
        endcase
    end

endmodule

// File: rtl/lcd_frame_streamer.sv
// Upstream byte source for a PCD8544 SPI transmitter: pulses the LCD reset
// pin, sends the init list, then on each frame_start sends the home-cursor
// commands followed by the whole frame buffer.
module lcd_frame_streamer
    import lcd_frame_streamer_pkg::*;
#(
    parameter int FB_BYTES   = FB_BYTES_DEFAULT,
    parameter int RST_CYCLES = RST_CYCLES_DEFAULT,
    parameter int INIT_LEN   = INIT_LEN_DEFAULT
) (
    input  logic                 clock,
    input  logic                 Reset,
    input  logic                 frame_start,
    lcd_frame_streamer_if.master bus,
    output logic                 lcd_rst_n,
    output logic                 init_done,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int               CNT_W     = $clog2(RST_CYCLES + 1);
    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [2:0]       INIT_LAST = 3'(INIT_LEN - 1);
    localparam logic [8:0]       IDX_LAST  = 9'(FB_BYTES - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] rst_cnt, rst_cnt_n;
    logic [2:0]       init_idx, init_idx_n;
    logic [2:0]       rom_idx;
    logic [7:0]       rom_byte;
    logic [8:0]       idx, idx_n;
    logic [8:0]       addr_q, addr_n;
    logic [7:0]       cmd_q, cmd_n;
    logic             valid_q, valid_n;
    logic             dc_q, dc_n;
    logic             lcd_rst_n_q, lcd_rst_n_n;
    logic             init_done_q, init_done_n;
    logic             frame_done_q, frame_done_n;
    logic             xfer;

    assign xfer = valid_q && bus.tx_ready;

    // Entry 0 is loaded while leaving LRST; inside INIT the ROM looks one ahead.
    assign rom_idx = (state == ST_INIT) ? init_idx + 3'd1 : 3'd0;

    lcd_frame_streamer_init_rom u_rom (
        .index (rom_idx),
        .value (rom_byte)
    );

    // State and output registers; synchronous reset restarts the whole sequence.
    always_ff @(posedge clock) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (Reset) begin
            state        <= ST_LRST;
            rst_cnt      <= '0;
            init_idx     <= '0;
            idx          <= '0;
            addr_q       <= '0;
            cmd_q        <= 8'h00;
            valid_q      <= 1'b0;
            dc_q         <= 1'b0;
            lcd_rst_n_q  <= 1'b0;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state        <= state_n;
            rst_cnt      <= rst_cnt_n;
            init_idx     <= init_idx_n;
            idx          <= idx_n;
            addr_q       <= addr_n;
            cmd_q        <= cmd_n;
            valid_q      <= valid_n;
            dc_q         <= dc_n;
            lcd_rst_n_q  <= lcd_rst_n_n;
            init_done_q  <= init_done_n;
            frame_done_q <= frame_done_n;
        end
    end

    // Next-state and next-output logic; everything holds unless a state moves it.
    always_comb begin
        state_n      = state;
        rst_cnt_n    = rst_cnt;
        init_idx_n   = init_idx;
        idx_n        = idx;
        addr_n       = addr_q;
        cmd_n        = cmd_q;
        valid_n      = valid_q;
        dc_n         = dc_q;
        lcd_rst_n_n  = lcd_rst_n_q;
        init_done_n  = init_done_q;
        frame_done_n = 1'b0;

        case (state)
            ST_LRST: begin
                if (rst_cnt == RST_LAST) begin
                    lcd_rst_n_n = 1'b1;
                    state_n     = ST_INIT;
                    valid_n     = 1'b1;
                    dc_n        = 1'b0;
                    cmd_n       = rom_byte;
                end else begin
                    rst_cnt_n = rst_cnt + CNT_W'(1);
                end
            end

            ST_INIT: begin
                if (xfer) begin
                    if (init_idx == INIT_LAST) begin
                        init_done_n = 1'b1;
                        valid_n     = 1'b0;
                        state_n     = ST_IDLE;
                    end else begin
                        init_idx_n = init_idx + 3'd1;
                        cmd_n      = rom_byte;
                    end
                end
            end

            ST_IDLE: begin
                // frame_done is still high in the first IDLE cycle; a request
                // coinciding with it belongs to the frame that just ended.
                if (frame_start && !frame_done_q) begin
                    state_n = ST_HOME0;
                    valid_n = 1'b1;
                    dc_n    = 1'b0;
                    cmd_n   = SET_Y;
                end
            end

            ST_HOME0: begin
                if (xfer) begin
                    state_n = ST_HOME1;
                    cmd_n   = SET_X;
                end
            end

            ST_HOME1: begin
                if (xfer) begin
                    state_n = ST_FETCH;
                    valid_n = 1'b0;
                    idx_n   = 9'd0;
                    addr_n  = 9'd0;
                end
            end

            ST_FETCH: begin
                state_n = ST_DATA;
                valid_n = 1'b1;
                dc_n    = 1'b1;
            end

            ST_DATA: begin
                if (xfer) begin
                    valid_n = 1'b0;
                    if (idx == IDX_LAST) begin
                        frame_done_n = 1'b1;
                        state_n      = ST_IDLE;
                    end else begin
                        idx_n   = idx + 9'd1;
                        addr_n  = idx + 9'd1;
                        state_n = ST_FETCH;
                    end
                end
            end

            default: state_n = ST_LRST;
        endcase
    end

    // In DATA the RAM's output register is the byte register: fb_addr is held
    // for the whole state, so its read data stays stable across stalls.
    assign bus.tx_data  = (state == ST_DATA) ? bus.fb_data : cmd_q;
    assign bus.tx_valid = valid_q;
    assign bus.tx_dc    = dc_q;
    assign bus.fb_addr  = addr_q;

    assign lcd_rst_n  = lcd_rst_n_q;
    assign init_done  = init_done_q;
    assign frame_done = frame_done_q;
    assign busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_lcd_frame_streamer.sv
// Self-checking bench for lcd_frame_streamer: directed command table,
// full-frame data checks, random back-pressure and reset/start corner cases.
module tb_lcd_frame_streamer;

    localparam int FB = 504;

    logic clock;
    logic Reset;
    logic frame_start;
    logic lcd_rst_n;
    logic init_done;
    logic busy;
    logic frame_done;

    lcd_frame_streamer_if bus ();

    lcd_frame_streamer dut (
        .clock       (clock),
        .Reset       (Reset),
        .frame_start (frame_start),
        .bus         (bus),
        .lcd_rst_n   (lcd_rst_n),
        .init_done   (init_done),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    typedef struct {
        int         stall;  // cycles tx_ready is held low before acceptance
        logic [7:0] data;   // expected byte
        logic       dc;     // expected D/C flag
    } cmd_vec_t;

    cmd_vec_t   cmd_tab [8];
    int         checks = 0;
    int         errors = 0;
    int         done_count = 0;
    logic [8:0] xq[$];
    logic [8:0] exp_q[$];

    logic       prev_valid = 1'b0;
    logic       prev_ready = 1'b0;
    logic       prev_reset = 1'b1;
    logic       prev_dc    = 1'b0;
    logic [7:0] prev_data  = 8'h00;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Synchronous frame-buffer RAM whose contents equal the low address byte.
    always @(posedge clock) bus.fb_data <= bus.fb_addr[7:0];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Transfer log, frame_done counter and hold-while-stalled checker.
    always @(negedge clock) begin
        if (!Reset && bus.tx_valid && bus.tx_ready) xq.push_back({bus.tx_dc, bus.tx_data});
        if (!Reset && frame_done) done_count++;
        if (!prev_reset && prev_valid && !prev_ready) begin
            check("stall valid held", bus.tx_valid, 1);
            check("stall byte held", {bus.tx_dc, bus.tx_data}, {prev_dc, prev_data});
        end
        prev_reset = Reset;
        prev_valid = bus.tx_valid;
        prev_ready = bus.tx_ready;
        prev_dc    = bus.tx_dc;
        prev_data  = bus.tx_data;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic count_rst_low(input string name);
        int n = 0;
        Reset = 1'b0;
        while (!lcd_rst_n && n < 300) begin
            n++;
            tick();
        end
        check(name, n, 100);
    endtask

    task automatic do_reset();
        Reset       = 1'b1;
        frame_start = 1'b0;
        repeat (10) tick();
        xq.delete();
        count_rst_low("lcd_rst_n low cycles");
    endtask

    task automatic wait_init(input string name);
        int n = 0;
        while (!init_done && n < 100) begin
            tick();
            n++;
        end
        check(name, init_done, 1);
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!frame_done && n < 3000) begin
            tick();
            n++;
        end
        check(name, frame_done, 1);
    endtask

    task automatic apply_cmd(input int i);
        for (int s = 0; s < cmd_tab[i].stall; s++) begin
            bus.tx_ready = 1'b0;
            check($sformatf("cmd%0d stalled byte", i), {bus.tx_valid, bus.tx_dc, bus.tx_data},
                  {1'b1, cmd_tab[i].dc, cmd_tab[i].data});
            tick();
        end
        bus.tx_ready = 1'b1;
        check($sformatf("cmd%0d byte", i), {bus.tx_valid, bus.tx_dc, bus.tx_data},
              {1'b1, cmd_tab[i].dc, cmd_tab[i].data});
        tick();
    endtask

    task automatic add_init();
        logic [7:0] rom [6] = '{8'h21, 8'hB1, 8'h04, 8'h14, 8'h20, 8'h0C};
        for (int i = 0; i < 6; i++) exp_q.push_back({1'b0, rom[i]});
    endtask

    task automatic add_frame();
        exp_q.push_back(9'h040);
        exp_q.push_back(9'h080);
        for (int i = 0; i < FB; i++) exp_q.push_back({1'b1, i[7:0]});
    endtask

    task automatic compare_xfers(input string name);
        int bad = 0;
        check({name, " count"}, xq.size(), exp_q.size());
        for (int i = 0; i < xq.size() && i < exp_q.size(); i++)
            if (xq[i] !== exp_q[i]) bad++;
        check({name, " mismatching bytes"}, bad, 0);
    endtask

    initial begin
        int n;
        int done0;
        bit pulsed;

        cmd_tab[0] = '{0, 8'h21, 1'b0};
        cmd_tab[1] = '{0, 8'hB1, 1'b0};
        cmd_tab[2] = '{0, 8'h04, 1'b0};
        cmd_tab[3] = '{0, 8'h14, 1'b0};
        cmd_tab[4] = '{0, 8'h20, 1'b0};
        cmd_tab[5] = '{0, 8'h0C, 1'b0};
        cmd_tab[6] = '{2, 8'h40, 1'b0};
        cmd_tab[7] = '{1, 8'h80, 1'b0};

        bus.tx_ready = 1'b1;
        frame_start  = 1'b0;
        Reset        = 1'b1;

        // 1: reset values, LCD reset pulse width, init list back-to-back.
        tick();
        check("reset lcd_rst_n", lcd_rst_n, 0);
        check("reset tx_valid", bus.tx_valid, 0);
        check("reset tx_data", bus.tx_data, 8'h00);
        check("reset tx_dc", bus.tx_dc, 0);
        check("reset fb_addr", bus.fb_addr, 9'd0);
        check("reset init_done", init_done, 0);
        check("reset busy", busy, 1);
        check("reset frame_done", frame_done, 0);
        repeat (9) tick();
        xq.delete();
        count_rst_low("lcd_rst_n low cycles");
        for (int i = 0; i < 6; i++) begin
            if (i == 5) check("init_done before last cmd", init_done, 0);
            apply_cmd(i);
        end
        check("init_done after 0C", init_done, 1);
        check("valid drops after init", bus.tx_valid, 0);
        check("idle not busy", busy, 0);
        exp_q.delete();
        add_init();
        compare_xfers("init list");

        // 2: full frame with tx_ready high, home commands with stalls.
        xq.delete();
        done0 = done_count;
        start_frame();
        check("busy after frame_start", busy, 1);
        for (int i = 6; i < 8; i++) apply_cmd(i);
        for (int i = 0; i < FB; i++) begin
            n = 0;
            while (!bus.tx_valid && n < 10) begin
                tick();
                n++;
            end
            check("one fetch cycle per byte", n, 1);
            check("data byte", {bus.tx_dc, bus.tx_data}, {1'b1, i[7:0]});
            check("fb_addr", bus.fb_addr, i[8:0]);
            tick();
        end
        check("frame_done after last byte", frame_done, 1);
        check("busy falls at frame end", busy, 0);
        check("valid drops at frame end", bus.tx_valid, 0);
        check("fb_addr holds last", bus.fb_addr, 9'd503);
        tick();
        check("frame_done one cycle", frame_done, 0);
        check("frame_done count", done_count - done0, 1);
        exp_q.delete();
        add_frame();
        compare_xfers("frame");

        // 3: random 30% tx_ready through init and a frame.
        Reset = 1'b1;
        repeat (10) tick();
        Reset = 1'b0;
        xq.delete();
        done0  = done_count;
        pulsed = 1'b0;
        n      = 0;
        while (done_count == done0 && n < 20000) begin
            bus.tx_ready = ($urandom_range(0, 9) < 3);
            frame_start  = init_done && !busy && !pulsed;
            if (frame_start) pulsed = 1'b1;
            tick();
            n++;
        end
        frame_start  = 1'b0;
        bus.tx_ready = 1'b1;
        check("random frame finished", done_count - done0, 1);
        exp_q.delete();
        add_init();
        add_frame();
        compare_xfers("random ready");

        // 4: frame_start during INIT and mid-frame is dropped.
        do_reset();
        check("in INIT", bus.tx_valid, 1);
        start_frame();
        wait_init("init after start in INIT");
        repeat (5) tick();
        check("no frame from INIT start", busy, 0);
        check("no bytes after init", xq.size(), 6);
        done0  = done_count;
        pulsed = 1'b0;
        start_frame();
        n = 0;
        while (done_count == done0 && n < 3000) begin
            frame_start = !pulsed && (xq.size() >= 6 + 2 + 200);
            if (frame_start) pulsed = 1'b1;
            tick();
            n++;
        end
        frame_start = 1'b0;
        repeat (20) tick();
        check("single frame_done", done_count - done0, 1);
        check("idle after ignored start", busy, 0);
        exp_q.delete();
        add_init();
        add_frame();
        compare_xfers("ignored starts");

        // 5: Reset at data byte 300 replays the LCD reset and init.
        xq.delete();
        done0 = done_count;
        start_frame();
        n = 0;
        while (xq.size() < 2 + 300 && n < 3000) begin
            tick();
            n++;
        end
        check("reached byte 300", xq.size(), 302);
        Reset = 1'b1;
        tick();
        check("mid reset tx_valid", bus.tx_valid, 0);
        check("mid reset lcd_rst_n", lcd_rst_n, 0);
        check("mid reset init_done", init_done, 0);
        check("mid reset busy", busy, 1);
        check("mid reset tx_data", bus.tx_data, 8'h00);
        check("mid reset fb_addr", bus.fb_addr, 9'd0);
        repeat (4) tick();
        xq.delete();
        count_rst_low("lcd_rst_n low after mid reset");
        wait_init("init replay");
        repeat (2) tick();
        check("no frame_done from aborted frame", done_count - done0, 0);
        exp_q.delete();
        add_init();
        compare_xfers("init replay");

        // 6: start coinciding with frame_done is ignored; next one in IDLE works.
        xq.delete();
        done0 = done_count;
        start_frame();
        wait_done("first frame_done");
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        check("start with frame_done ignored", busy, 0);
        repeat (3) tick();
        check("still idle", {busy, bus.tx_valid}, 2'b00);
        start_frame();
        check("second start accepted", {busy, bus.tx_valid, bus.tx_data}, {2'b11, 8'h40});
        wait_done("second frame_done");
        tick();
        check("two frame_done pulses", done_count - done0, 2);
        exp_q.delete();
        add_frame();
        add_frame();
        compare_xfers("back-to-back frames");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
